// File: rtl/gpu_pkg.sv
// Shared types and Avalon-MM widths for the GPU memory path.
// Holds the arbiter state encoding used by gpu_mem_arbiter.
package gpu;

    localparam int AV_ADDR_BITS = 32;
    localparam int AV_DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RWAIT = 2'd2
    } arb_state_e;

endpackage

// File: rtl/gpu_rr_pick.sv
// Round-robin selector: returns the first pending slot strictly after ptr,
// wrapping modulo NUM_REQ. Purely combinational.
module gpu_rr_pick #(
    parameter int NUM_REQ  = 4,
    parameter int REQ_BITS = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0]  pending,
    input  logic [REQ_BITS-1:0] ptr,
    output logic                found,
    output logic [REQ_BITS-1:0] idx
);

    int                  cand_int;
    logic [REQ_BITS-1:0] cand_idx;

    // Scan offsets from farthest to nearest so the nearest pending slot wins.
    always_comb begin
        found    = 1'b0;
        idx      = '0;
        cand_int = 0;
        cand_idx = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand_int = (int'(ptr) + k) % NUM_REQ;
            cand_idx = REQ_BITS'(cand_int);
            if (pending[cand_idx]) begin
                found = 1'b1;
                idx   = cand_idx;
            end
        end
    end

endmodule

// File: rtl/gpu_mem_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM byte master between NUM_REQ
// gpu_controller requesters. One downstream transaction at a time; the
// owner's command is latched at grant and completion is routed to it only.
// Optional read watchdog: define GPU_ARB_READ_TIMEOUT_EN.
module gpu_mem_arbiter
    import gpu::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int REQ_BITS = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    parameter int TIMEOUT  = 255
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [AV_ADDR_BITS*NUM_REQ-1:0]  s_address,
    input  logic [AV_DATA_BITS*NUM_REQ-1:0]  s_writedata,
    input  logic [NUM_REQ-1:0]               s_write,
    input  logic [NUM_REQ-1:0]               s_read,
    output logic [NUM_REQ-1:0]               s_waitrequest,
    output logic [AV_DATA_BITS*NUM_REQ-1:0]  s_readdata,
    output logic [NUM_REQ-1:0]               s_readdatavalid,
    output logic [AV_ADDR_BITS-1:0]          m_address,
    output logic [AV_DATA_BITS-1:0]          m_writedata,
    output logic                             m_write,
    output logic                             m_read,
    input  logic                             m_waitrequest,
    input  logic [AV_DATA_BITS-1:0]          m_readdata,
    input  logic                             m_readdatavalid,
    output logic [REQ_BITS-1:0]              grant_idx,
    output logic                             busy,
    output logic                             timeout_err
);

    arb_state_e                state_q, state_d;
    logic [REQ_BITS-1:0]       ptr_q, ptr_d;
    logic [REQ_BITS-1:0]       grant_q, grant_d;
    logic [AV_ADDR_BITS-1:0]   cmd_addr_q, cmd_addr_d;
    logic [AV_DATA_BITS-1:0]   cmd_data_q, cmd_data_d;
    logic                      cmd_read_q, cmd_read_d;

    logic                      complete;
    logic [AV_DATA_BITS-1:0]   rd_data;

    logic [NUM_REQ-1:0]        pending;
    logic [AV_ADDR_BITS-1:0]   slot_addr  [NUM_REQ];
    logic [AV_DATA_BITS-1:0]   slot_wdata [NUM_REQ];
    logic                      pick_found;
    logic [REQ_BITS-1:0]       pick_idx;

    // Unflatten requester buses and route completion back to the owner only.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slot
            logic owner;
            assign slot_addr[gi]  = s_address[gi*AV_ADDR_BITS +: AV_ADDR_BITS];
            assign slot_wdata[gi] = s_writedata[gi*AV_DATA_BITS +: AV_DATA_BITS];
            // A simultaneous read+write is still a single pending access.
            assign pending[gi]    = s_read[gi] | s_write[gi];
            assign owner          = (grant_q == REQ_BITS'(gi));
            assign s_waitrequest[gi]   = ~(complete & owner);
            assign s_readdatavalid[gi] = complete & owner & cmd_read_q;
            assign s_readdata[gi*AV_DATA_BITS +: AV_DATA_BITS] =
                (complete & owner & cmd_read_q) ? rd_data : '0;
        end
    endgenerate

    gpu_rr_pick #(
        .NUM_REQ  (NUM_REQ),
        .REQ_BITS (REQ_BITS)
    ) u_pick (
        .pending (pending),
        .ptr     (ptr_q),
        .found   (pick_found),
        .idx     (pick_idx)
    );

`ifdef GPU_ARB_READ_TIMEOUT_EN
    localparam int CNT_BITS = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic                timeout_err_q, timeout_err_d;
    assign timeout_err = timeout_err_q;
`else
    // Without the watchdog a read in RWAIT waits forever and TIMEOUT is inert.
    localparam bit TIMEOUT_INERT = (TIMEOUT != 0);
    assign timeout_err = TIMEOUT_INERT & 1'b0;
`endif

    // Next-state, grant latch and completion detection.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        cmd_addr_d = cmd_addr_q;
        cmd_data_d = cmd_data_q;
        cmd_read_d = cmd_read_q;
        complete   = 1'b0;
        rd_data    = m_readdata;
`ifdef GPU_ARB_READ_TIMEOUT_EN
        cnt_d         = cnt_q;
        timeout_err_d = timeout_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d    = pick_idx;
                    cmd_addr_d = slot_addr[pick_idx];
                    cmd_data_d = slot_wdata[pick_idx];
                    cmd_read_d = s_read[pick_idx];
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (!m_waitrequest) begin
                    if (!cmd_read_q || m_readdatavalid) begin
                        complete = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        state_d = RWAIT;
`ifdef GPU_ARB_READ_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end
                end
            end
            RWAIT: begin
                if (m_readdatavalid) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end
`ifdef GPU_ARB_READ_TIMEOUT_EN
                else if (cnt_q + CNT_BITS'(1) == CNT_BITS'(TIMEOUT)) begin
                    complete      = 1'b1;
                    rd_data       = '0;
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_BITS'(1);
                end
`endif
            end
            default: state_d = IDLE;
        endcase
        if (complete) begin
            ptr_d = grant_q;
        end
    end

    // State and command registers; reset favours slot 0 next.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= REQ_BITS'(NUM_REQ - 1);
            grant_q    <= '0;
            cmd_addr_q <= '0;
            cmd_data_q <= '0;
            cmd_read_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            cmd_addr_q <= cmd_addr_d;
            cmd_data_q <= cmd_data_d;
            cmd_read_q <= cmd_read_d;
        end
    end

`ifdef GPU_ARB_READ_TIMEOUT_EN
    // Watchdog counter and sticky error flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end
`endif

    // Downstream command comes only from the latched command and the state.
    always_comb begin
        m_read      = (state_q == ISSUE) &  cmd_read_q;
        m_write     = (state_q == ISSUE) & ~cmd_read_q;
        m_address   = (state_q == ISSUE) ? cmd_addr_q : '0;
        m_writedata = (state_q == ISSUE) ? cmd_data_q : '0;
    end

    assign grant_idx = grant_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_gpu_mem_arbiter.sv
// Directed bench for gpu_mem_arbiter: write, read with latency, round robin,
// reset during a read, and the read watchdog (GPU_ARB_READ_TIMEOUT_EN).
module tb_gpu_mem_arbiter;

    localparam int N  = 4;
    localparam int TO = 10;

    logic              clock = 1'b0;
    logic              reset;
    logic [32*N-1:0]   s_address;
    logic [8*N-1:0]    s_writedata;
    logic [N-1:0]      s_write;
    logic [N-1:0]      s_read;
    logic [N-1:0]      s_waitrequest;
    logic [8*N-1:0]    s_readdata;
    logic [N-1:0]      s_readdatavalid;
    logic [31:0]       m_address;
    logic [7:0]        m_writedata;
    logic              m_write;
    logic              m_read;
    logic              m_waitrequest;
    logic [7:0]        m_readdata;
    logic              m_readdatavalid;
    logic [1:0]        grant_idx;
    logic              busy;
    logic              timeout_err;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    always #5 clock = ~clock;

    gpu_mem_arbiter #(
        .NUM_REQ  (N),
        .REQ_BITS (2),
        .TIMEOUT  (TO)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .s_address       (s_address),
        .s_writedata     (s_writedata),
        .s_write         (s_write),
        .s_read          (s_read),
        .s_waitrequest   (s_waitrequest),
        .s_readdata      (s_readdata),
        .s_readdatavalid (s_readdatavalid),
        .m_address       (m_address),
        .m_writedata     (m_writedata),
        .m_write         (m_write),
        .m_read          (m_read),
        .m_waitrequest   (m_waitrequest),
        .m_readdata      (m_readdata),
        .m_readdatavalid (m_readdatavalid),
        .grant_idx       (grant_idx),
        .busy            (busy),
        .timeout_err     (timeout_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else begin
            pass_cnt++;
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int nw, nlow2, nother, first_c, nrd, nrdv, rdv_c, nlow0, ngr, nto, to_c;
        logic [31:0] wa;
        logic [7:0]  wd, rd;
        logic        w_at;
        int          order [6];

        reset = 1'b1;
        s_address = '0; s_writedata = '0; s_write = '0; s_read = '0;
        m_waitrequest = 1'b1; m_readdata = '0; m_readdatavalid = 1'b0;
        tick; tick; tick;
        @(negedge clock);
        check("rst_m_write", m_write, 0);
        check("rst_m_read", m_read, 0);
        check("rst_m_address", m_address, 0);
        check("rst_s_wait", s_waitrequest, 4'hF);
        check("rst_s_rdv", s_readdatavalid, 0);
        check("rst_busy", busy, 0);
        check("rst_grant", grant_idx, 0);
        check("rst_timeout_err", timeout_err, 0);
        reset = 1'b0;
        tick;

        // Single write: slot 2, 0x1000 <- 0xA5, memory stalls 2 cycles.
        s_write = 4'b0100;
        s_address[2*32 +: 32] = 32'h1000;
        s_writedata[2*8 +: 8] = 8'hA5;
        tick;
        s_write = '0;
        nw = 0; nlow2 = 0; nother = 0; first_c = -1; wa = '0; wd = '0;
        for (int c = 0; c < 6; c++) begin
            m_waitrequest = (c < 2);
            @(negedge clock);
            if (m_write) begin
                nw++;
                wa = m_address;
                wd = m_writedata;
                if (first_c < 0) first_c = c;
            end
            if (!s_waitrequest[2]) nlow2++;
            if ((~s_waitrequest & 4'b1011) != 0) nother++;
            tick;
        end
        check("wr_m_write_cycles", nw, 3);
        check("wr_first_cycle", first_c, 0);
        check("wr_address", wa, 32'h1000);
        check("wr_data", wd, 8'hA5);
        check("wr_owner_wait_low", nlow2, 1);
        check("wr_others_wait_low", nother, 0);
        check("wr_busy_after", busy, 0);

        // Read slot 0 at 0x2000, data 0x5C three cycles after accept.
        s_read = 4'b0001;
        s_address[0 +: 32] = 32'h2000;
        m_waitrequest = 1'b0;
        tick;
        s_read = '0;
        nrd = 0; nrdv = 0; rdv_c = -1; nlow0 = 0; rd = '0; w_at = 1'b1; nother = 0;
        for (int c = 0; c < 6; c++) begin
            m_readdatavalid = (c == 3);
            m_readdata      = (c == 3) ? 8'h5C : 8'hEE;
            @(negedge clock);
            if (m_read) nrd++;
            if (s_readdatavalid[0]) begin
                nrdv++;
                rdv_c = c;
                rd    = s_readdata[7:0];
                w_at  = s_waitrequest[0];
            end
            if (!s_waitrequest[0]) nlow0++;
            if (s_readdatavalid[3:1] != 0 || s_readdata[31:8] != 0) nother++;
            tick;
        end
        m_readdatavalid = 1'b0;
        check("rd_m_read_cycles", nrd, 1);
        check("rd_rdv_count", nrdv, 1);
        check("rd_rdv_cycle", rdv_c, 3);
        check("rd_data", rd, 8'h5C);
        check("rd_wait_at_rdv", w_at, 0);
        check("rd_wait_low_count", nlow0, 1);
        check("rd_others_quiet", nother, 0);

        // Round robin after reset: all slots continuously reading, zero latency.
        reset = 1'b1; tick; reset = 1'b0;
        m_waitrequest = 1'b0; m_readdatavalid = 1'b1; m_readdata = 8'h42;
        s_read = 4'hF;
        ngr = 0;
        for (int k = 0; k < 6; k++) order[k] = -1;
        for (int c = 0; c < 30; c++) begin
            if (ngr < 6) begin
                @(negedge clock);
                if (s_readdatavalid != 0) begin
                    for (int b = 0; b < N; b++)
                        if (s_readdatavalid[b]) order[ngr] = b;
                    ngr++;
                end
                tick;
            end
        end
        s_read = '0;
        tick; tick;
        m_readdatavalid = 1'b0;
        check("rr_grant_count", ngr, 6);
        for (int k = 0; k < 6; k++) check($sformatf("rr_order_%0d", k), order[k], k % N);

        // Reset while in RWAIT, stale read data one cycle after.
        s_read = 4'b1000;
        s_address[3*32 +: 32] = 32'h3000;
        tick;
        s_read = '0;
        tick;
        @(negedge clock);
        check("rst_mid_in_rwait", {busy, m_read}, 2'b10);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        m_readdatavalid = 1'b1;
        m_readdata = 8'h99;
        nrdv = 0;
        @(negedge clock);
        if (s_readdatavalid != 0) nrdv++;
        check("rst_mid_wait", s_waitrequest, 4'hF);
        check("rst_mid_rdata", s_readdata, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_grant", grant_idx, 0);
        tick;
        m_readdatavalid = 1'b0;
        @(negedge clock);
        if (s_readdatavalid != 0) nrdv++;
        check("rst_mid_no_rdv", nrdv, 0);
        s_read = 4'b1001;
        s_address[0 +: 32] = 32'h4000;
        m_waitrequest = 1'b1;
        tick;
        @(negedge clock);
        check("rst_next_grant", grant_idx, 0);
        check("rst_next_addr", m_address, 32'h4000);
        tick;
        s_read = '0;
        m_waitrequest = 1'b0;
        m_readdatavalid = 1'b1;
        m_readdata = 8'h11;
        tick;
        m_readdatavalid = 1'b0;
        tick;

        // Read that never returns data.
        s_read = 4'b0010;
        s_address[1*32 +: 32] = 32'h5000;
        tick;
        s_read = '0;
        nto = 0; to_c = -1; rd = 8'hFF;
        for (int c = 0; c < 30; c++) begin
            @(negedge clock);
            if (s_readdatavalid[1]) begin
                nto++;
                to_c = c;
                rd   = s_readdata[15:8];
            end
            tick;
        end
`ifdef GPU_ARB_READ_TIMEOUT_EN
        check("to_completions", nto, 1);
        check("to_cycle", to_c, TO);
        check("to_data", rd, 0);
        check("to_err_set", timeout_err, 1);
        check("to_busy_after", busy, 0);
        tick; tick; tick;
        @(negedge clock);
        check("to_err_sticky", timeout_err, 1);
`else
        check("to_completions", nto, 0);
        check("to_busy_stuck", busy, 1);
        check("to_err_tied", timeout_err, 0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
